dmac_fifo_ext: RTL and testbench

//  Parametrised successor to the DMAC data FIFO: synchronous single-clock FIFO between the

---
 rtl/dmac_fifo_ext_if.sv | 29 ++
 rtl/dmac_fifo_ext.sv | 116 +++++++++++
 tb/tb_dmac_fifo_ext.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/dmac_fifo_ext_if.sv
// Bus bundle between the DMAC engines and the per-channel data FIFO.
// The master modport is the engine side, the slave modport is the FIFO side.
interface dmac_fifo_ext_if #(
    parameter int unsigned DEPTH_LG2  = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  clr_i;
    logic                  wren_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  rden_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  full_o;
    logic                  afull_o;
    logic                  empty_o;
    logic                  aempty_o;
    logic [DEPTH_LG2:0]    count_o;
    logic                  ovf_o;
    logic                  udf_o;

    modport master (
        output clr_i, wren_i, wdata_i, rden_i,
        input  rdata_o, full_o, afull_o, empty_o, aempty_o, count_o, ovf_o, udf_o
    );

    modport slave (
        input  clr_i, wren_i, wdata_i, rden_i,
        output rdata_o, full_o, afull_o, empty_o, aempty_o, count_o, ovf_o, udf_o
    );
endinterface

// File: rtl/dmac_fifo_ext.sv
// Single-clock data FIFO between the DMAC read and write engines.
// Occupancy is the difference of the wrap-bit pointers, so no separate
// count register can drift out of step with the pointers.
module dmac_fifo_ext #(
    parameter int unsigned DEPTH_LG2  = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned AFULL_LVL  = 14,
    parameter int unsigned AEMPTY_LVL = 2,
    parameter bit          FWFT       = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    dmac_fifo_ext_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LG2;
    localparam int unsigned CW    = DEPTH_LG2 + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

    if (DEPTH_LG2 < 1) begin : g_bad_depth
        $error("dmac_fifo_ext: DEPTH_LG2 must be at least 1");
    end
    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
        $error("dmac_fifo_ext: AFULL_LVL must be in 1..DEPTH");
    end
    if (AEMPTY_LVL > DEPTH - 1) begin : g_bad_aempty
        $error("dmac_fifo_ext: AEMPTY_LVL must be in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]         wptr_q;
    logic [CW-1:0]         rptr_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [DEPTH_LG2-1:0]  waddr;
    logic [DEPTH_LG2-1:0]  raddr;

    assign waddr = wptr_q[DEPTH_LG2-1:0];
    assign raddr = rptr_q[DEPTH_LG2-1:0];

    // Wrap-bit difference gives 0..DEPTH without aliasing full and empty.
    assign count = wptr_q - rptr_q;
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // Clear wins over both requests in the same cycle.
    assign wr_ok = bus.wren_i && !full  && !bus.clr_i;
    assign rd_ok = bus.rden_i && !empty && !bus.clr_i;

    assign bus.count_o  = count;
    assign bus.full_o   = full;
    assign bus.empty_o  = empty;
    assign bus.afull_o  = (count >= AFULL_C);
    assign bus.aempty_o = (count <= AEMPTY_C);
    assign bus.ovf_o    = ovf_q;
    assign bus.udf_o    = udf_q;

    // Storage write; the array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[waddr] <= bus.wdata_i;
        end
    end

    // Pointer advance, synchronous clear and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else if (bus.clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (rd_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (bus.wren_i && full) begin
                ovf_q <= 1'b1;
            end
            if (bus.rden_i && empty) begin
                udf_q <= 1'b1;
            end
        end
    end

    if (FWFT) begin : g_fwft
        assign bus.rdata_o = mem[raddr];
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] rdata_q;

        // Registered read port: loads only on an accepted read, holds otherwise.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q <= '0;
            end else if (rd_ok) begin
                rdata_q <= mem[raddr];
            end
        end

        assign bus.rdata_o = rdata_q;
    end
endmodule

// File: tb/tb_dmac_fifo_ext.sv
// Bench for dmac_fifo_ext: one registered-read and one FWFT instance share stimulus.
module tb_dmac_fifo_ext;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmac_fifo_ext_if #(.DEPTH_LG2(4), .DATA_WIDTH(32)) bus0 ();
    dmac_fifo_ext_if #(.DEPTH_LG2(4), .DATA_WIDTH(32)) bus1 ();

    dmac_fifo_ext #(
        .DEPTH_LG2(4), .DATA_WIDTH(32), .AFULL_LVL(14), .AEMPTY_LVL(2), .FWFT(1'b0)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    dmac_fifo_ext #(
        .DEPTH_LG2(4), .DATA_WIDTH(32), .AFULL_LVL(14), .AEMPTY_LVL(2), .FWFT(1'b1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        logic        w;
        logic        r;
        logic        c;
        logic [31:0] d;
        int          cnt;
        logic        ovf;
        logic        udf;
        logic        chk0;
        logic [31:0] rd0;
        logic        chk1;
        logic [31:0] rd1;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic chk_one(input string tag, input logic [4:0] cnt, input logic e,
                           input logic f, input logic af, input logic ae, input logic o,
                           input logic u, input int ecnt, input logic eo, input logic eu);
        chk({tag, ".count"},  32'(cnt), 32'(ecnt));
        chk({tag, ".empty"},  32'(e),   32'(ecnt == 0));
        chk({tag, ".full"},   32'(f),   32'(ecnt == 16));
        chk({tag, ".afull"},  32'(af),  32'(ecnt >= 14));
        chk({tag, ".aempty"}, 32'(ae),  32'(ecnt <= 2));
        chk({tag, ".ovf"},    32'(o),   32'(eo));
        chk({tag, ".udf"},    32'(u),   32'(eu));
    endtask

    task automatic chk_state(input string tag, input int ecnt, input logic eo, input logic eu);
        chk_one({"f0.", tag}, bus0.count_o, bus0.empty_o, bus0.full_o, bus0.afull_o,
                bus0.aempty_o, bus0.ovf_o, bus0.udf_o, ecnt, eo, eu);
        chk_one({"f1.", tag}, bus1.count_o, bus1.empty_o, bus1.full_o, bus1.afull_o,
                bus1.aempty_o, bus1.ovf_o, bus1.udf_o, ecnt, eo, eu);
    endtask

    task automatic drive(input logic w, input logic r, input logic c, input logic [31:0] d);
        bus0.wren_i = w; bus0.rden_i = r; bus0.clr_i = c; bus0.wdata_i = d;
        bus1.wren_i = w; bus1.rden_i = r; bus1.clr_i = c; bus1.wdata_i = d;
    endtask

    // Apply one cycle of stimulus, then sample 1 ns after the edge.
    task automatic step(input logic w, input logic r, input logic c, input logic [31:0] d);
        drive(w, r, c, d);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    vec_t        vecs[15];
    logic [31:0] q[$];
    logic [31:0] e;

    initial begin
        // Hand-computed vectors starting from a cleared, empty FIFO.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'hA5, 1, 1'b0, 1'b1, 1'b1, 32'h10F, 1'b1, 32'hA5};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'hB6, 2, 1'b0, 1'b1, 1'b1, 32'h10F, 1'b1, 32'hA5};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1, 1'b0, 1'b1, 1'b1, 32'hA5,  1'b1, 32'hB6};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'hC7, 1, 1'b0, 1'b1, 1'b1, 32'hB6,  1'b1, 32'hC7};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,  0, 1'b0, 1'b1, 1'b1, 32'hC7,  1'b0, 32'h0};
        for (int k = 0; k < 7; k++) begin
            vecs[5+k] = '{1'b1, 1'b0, 1'b0, 32'hD0 + 32'(k), k + 1, 1'b0, 1'b1,
                          1'b1, 32'hC7, 1'b1, 32'hD0};
        end
        vecs[12] = '{1'b1, 1'b1, 1'b1, 32'hEE, 0, 1'b0, 1'b0, 1'b1, 32'hC7, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 32'hF0, 1, 1'b0, 1'b0, 1'b1, 32'hC7, 1'b1, 32'hF0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0,  0, 1'b0, 1'b0, 1'b1, 32'hF0, 1'b0, 32'h0};

        drive(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_state("reset", 0, 1'b0, 1'b0);
        chk("f0.reset.rdata", bus0.rdata_o, 32'h0);

        // Async reset mid-stream.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_state("udf_pre", 0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h50 + 32'(i));
        chk_state("pre_rst", 5, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("f0.pre_rst.rdata", bus0.rdata_o, 32'h50);
        #3;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 0, 1'b0, 1'b0);
        chk("f0.async_rst.rdata", bus0.rdata_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill, overflow, drain, underflow, clear.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h100 + 32'(i));
            chk_state("fill", i + 1, 1'b0, 1'b0);
            chk("f1.fill.head", bus1.rdata_o, 32'h100);
        end
        chk("f0.fill.noload", bus0.rdata_o, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h999);
        chk_state("ovf", 16, 1'b1, 1'b0);
        chk("f1.ovf.head", bus1.rdata_o, 32'h100);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            chk_state("drain", 15 - i, 1'b1, 1'b0);
            chk("f0.drain.data", bus0.rdata_o, 32'h100 + 32'(i));
            if (i < 15) chk("f1.drain.head", bus1.rdata_o, 32'h101 + 32'(i));
        end
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_state("udf", 0, 1'b1, 1'b1);
        chk("f0.udf.hold", bus0.rdata_o, 32'h10F);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk_state("clr", 0, 1'b0, 1'b0);
        chk("f0.clr.hold", bus0.rdata_o, 32'h10F);

        // Table: empty+both, streaming, clear at count 7 with both requests.
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].w, vecs[i].r, vecs[i].c, vecs[i].d);
            chk_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ovf, vecs[i].udf);
            if (vecs[i].chk0) chk($sformatf("f0.vec%0d.rdata", i), bus0.rdata_o, vecs[i].rd0);
            if (vecs[i].chk1) chk($sformatf("f1.vec%0d.rdata", i), bus1.rdata_o, vecs[i].rd1);
        end

        // Full + both requests: read wins, write rejected.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 32'h200 + 32'(i));
        chk_state("full2", 16, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'hBEEF);
        chk_state("full_both", 15, 1'b1, 1'b0);
        chk("f0.full_both.rdata", bus0.rdata_o, 32'h200);
        chk("f1.full_both.head", bus1.rdata_o, 32'h201);
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            chk("f0.full_drain.data", bus0.rdata_o, 32'h201 + 32'(i));
            if (i < 14) chk("f1.full_drain.head", bus1.rdata_o, 32'h202 + 32'(i));
        end
        chk_state("full_drained", 0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h0);

        // Wrap: three passes of 12 writes / 12 reads with overlapped cycles.
        for (int p = 0; p < 3; p++) begin
            for (int s = 0; s < 18; s++) begin
                logic w;
                logic r;
                w = (s < 12);
                r = (s >= 6);
                if (r) chk("f1.wrap.head", bus1.rdata_o, q[0]);
                step(w, r, 1'b0, 32'h300 + 32'(p * 16 + s));
                if (w) q.push_back(32'h300 + 32'(p * 16 + s));
                if (r) begin
                    e = q.pop_front();
                    chk("f0.wrap.data", bus0.rdata_o, e);
                end
                chk("f0.wrap.count", 32'(bus0.count_o), 32'(q.size()));
                chk("f1.wrap.count", 32'(bus1.count_o), 32'(q.size()));
            end
        end
        chk_state("wrap_end", 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
